// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage and IF/ID pipeline register for the 5-stage
//   RV32I core. Issues word fetches over a req/ready instruction-memory
//   interface, parks a returned instruction in a one-entry skid buffer while
//   the pipeline is stalled, and presents the result to decode.
//
// Ports
//   clk, rst            core clock; synchronous active-high reset
//   StallF, StallD      hazard-unit stalls for fetch and the IF/ID register
//   FlushD              clear IF/ID to a NOP bubble
//   PCSrcE, PCTargetE   taken branch/jump redirect from execute
//   imem_req/addr       fetch request and word address (bits [1:0] = 0)
//   imem_ready/rdata    transfer completes when imem_req && imem_ready
//   InstrD, PCD,
//   PCPlus4D, ValidD    IF/ID register contents (ValidD = 0 for bubbles)

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  // IDLE  : one quiet cycle after reset
  // REQ   : request outstanding at PCF
  // HOLD  : response parked in the skid buffer, waiting for the stall to clear
  // DRAIN : redirected while a request was outstanding; swallow the old response
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_t;

  // What the IF/ID register does this cycle
  typedef enum logic [1:0] {IFID_HOLD, IFID_BUBBLE, IFID_MEM, IFID_SKID} ifid_sel_t;

  fetch_state_t state, state_next;
  ifid_sel_t    ifid_sel;

  logic [31:0] pcf, pcf_next;
  logic [31:0] pcf_plus4;
  logic [31:0] drain_addr, drain_addr_next;
  logic [31:0] skid_data, skid_data_next;
  logic [31:0] redirect_pc;

  // PCF+4 wraps naturally at 32 bits.
  assign pcf_plus4   = pcf + 32'd4;
  assign redirect_pc = PCTargetE & ~32'h0000_0003;

  // State register, PC, drain address and skid buffer. The skid buffer only
  // holds meaningful data while in HOLD, so leaving HOLD is what empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pcf        <= RESET_PC;
      drain_addr <= RESET_PC;
      skid_data  <= NOP_INSTR;
    end else begin
      state      <= state_next;
      pcf        <= pcf_next;
      drain_addr <= drain_addr_next;
      skid_data  <= skid_data_next;
    end
  end

  // Next-state, PC update and memory request. A redirect wins over
  // everything else in every state.
  always_comb begin
    state_next      = state;
    pcf_next        = pcf;
    drain_addr_next = drain_addr;
    skid_data_next  = skid_data;
    imem_req        = 1'b0;
    imem_addr       = pcf;
    ifid_sel        = StallD ? IFID_HOLD : IFID_BUBBLE;

    case (state)
      IDLE: begin
        state_next = REQ;
        if (PCSrcE) pcf_next = redirect_pc;
      end

      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pcf;
        if (PCSrcE) begin
          pcf_next = redirect_pc;
          // A response landing this cycle is simply dropped; otherwise the
          // old request is still in flight and must be drained first.
          if (!imem_ready) begin
            state_next      = DRAIN;
            drain_addr_next = pcf;
          end
        end else if (imem_ready) begin
          if (StallF || StallD) begin
            skid_data_next = imem_rdata;
            state_next     = HOLD;
          end else begin
            ifid_sel = IFID_MEM;
            pcf_next = pcf_plus4;
          end
        end
      end

      HOLD: begin
        if (PCSrcE) begin
          pcf_next   = redirect_pc;
          state_next = REQ;
        end else if (!StallF && !StallD) begin
          ifid_sel   = IFID_SKID;
          pcf_next   = pcf_plus4;
          state_next = REQ;
        end
      end

      DRAIN: begin
        // Keep the original address on the bus until the stale response
        // arrives. A further redirect only updates the PC and keeps draining.
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        if (PCSrcE) begin
          pcf_next = redirect_pc;
        end else if (imem_ready) begin
          state_next = REQ;
        end
      end

      default: state_next = IDLE;
    endcase

    // Flush overrides stall and any accept; the PC update above still stands.
    if (FlushD) ifid_sel = IFID_BUBBLE;
  end

  // IF/ID pipeline register. Bubbles keep PCD/PCPlus4D unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else begin
      case (ifid_sel)
        IFID_BUBBLE: begin
          InstrD <= NOP_INSTR;
          ValidD <= 1'b0;
        end
        IFID_MEM: begin
          InstrD   <= imem_rdata;
          PCD      <= pcf;
          PCPlus4D <= pcf_plus4;
          ValidD   <= 1'b1;
        end
        IFID_SKID: begin
          InstrD   <= skid_data;
          PCD      <= pcf;
          PCPlus4D <= pcf_plus4;
          ValidD   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage RV32I pipeline core.
- Generates PCF and drives a req/ready instruction-memory interface.
- Holds a fetched instruction in a one-entry skid buffer when decode is stalled.
- Presents InstrD/PCD/PCPlus4D to decode, obeying StallF/StallD from the hazard unit and FlushD/PCSrcE redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC of first fetch after reset.
- NOP_INSTR, 32'h0000_0013, instruction loaded into IF/ID on bubble or flush (addi x0,x0,0).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- StallF  input  1  from hazard unit; freeze PC/fetch acceptance.
- StallD  input  1  from hazard unit; hold IF/ID contents.
- FlushD  input  1  clear IF/ID to NOP.
- PCSrcE  input  1  taken branch/jump resolved in EX.
- PCTargetE  input  32  redirect target.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch word address, bits [1:0] always 2'b00.
- imem_ready  input  1  transfer completes in any cycle where imem_req && imem_ready.
- imem_rdata  input  32  instruction, valid when imem_ready.
- InstrD  output  32  decode instruction.
- PCD  output  32  PC of InstrD.
- PCPlus4D  output  32  PCD+4.
- ValidD  output  1  InstrD is a real fetched instruction (0 = bubble).

Behaviour:
- Reset values (next edge with rst=1, overrides all inputs):
  - PCF=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - Skid buffer empty.
- Memory protocol:
  - While imem_req=1 and imem_ready=0, imem_addr is held stable.
  - imem_ready is ignored when imem_req=0.
  - Zero-wait memory (ready in the same cycle as req) is supported.
- FSM states: IDLE, REQ, HOLD, DRAIN.
- IDLE: imem_req=0. Go to REQ after one cycle.
- REQ: imem_req=1, imem_addr=PCF.
  - Accept = imem_ready && !StallF && !StallD && !PCSrcE.
  - On accept, IF/ID loads {imem_rdata, PCF, PCF+4}, ValidD=1, and PCF<=PCF+4. Stay in REQ, so the next request issues the following cycle.
  - imem_ready && (StallF||StallD) && !PCSrcE: response goes to the skid buffer, IF/ID holds, go to HOLD.
  - !imem_ready && !StallD: IF/ID loads a bubble (NOP_INSTR, ValidD=0, PCD/PCPlus4D unchanged).
  - !imem_ready && StallD: IF/ID holds.
- HOLD: imem_req=0. When !StallF && !StallD, IF/ID loads the buffer, ValidD=1, PCF<=PCF+4, go to REQ.
- Redirect (PCSrcE=1) has top priority in every state:
  - PCF<=PCTargetE with bits [1:0] cleared.
  - Skid buffer is discarded.
  - REQ with imem_ready=1 this cycle: response discarded, stay in REQ.
  - REQ with imem_ready=0: go to DRAIN.
  - HOLD or IDLE: go to REQ (IDLE only if rst=0).
- DRAIN: imem_req=1 with the old imem_addr held until imem_ready. The response is discarded, then go to REQ with the new PCF. Another PCSrcE in DRAIN overwrites PCF and stays in DRAIN.
- FlushD: IF/ID loads NOP_INSTR with ValidD=0. Priority over StallD and over any accept in the same cycle; the accepted PC still advances unless PCSrcE=1.
- Arithmetic: PCF+4 is 32-bit and wraps 32'hFFFF_FFFC to 32'h0000_0000.
- StallF without StallD: the response is buffered (same as StallD) and IF/ID loads a bubble.

Test Plan:
- Reset, zero-wait memory returning mem[a]=a|0xA000_0000 → first imem_req 2 cycles after rst falls at addr 0x0; InstrD sequence 0xA000_0000, 0xA000_0004, 0xA000_0008 on consecutive cycles, ValidD=1, PCPlus4D=PCD+4.
- 2-cycle-latency memory → each valid InstrD is preceded by one NOP_INSTR/ValidD=0 cycle; imem_addr is stable while waiting.
- StallD=1 for 3 cycles coinciding with ready for addr 0x8 → InstrD frozen, imem_req=0 in HOLD. On release, InstrD=mem[0x8], ValidD=1; next imem_addr=0xC.
- Request for 0x8 outstanding, PCSrcE=1 with PCTargetE=0x103 → DRAIN keeps addr 0x8 until ready. The 0x8 data never appears on InstrD. Next request addr is 0x100, then InstrD=mem[0x100].
- FlushD=1 and StallD=1 with ready in the same cycle → InstrD=NOP_INSTR, ValidD=0.
- rst asserted while in HOLD and in DRAIN → next cycle all outputs at reset values, imem_req=0. The buffered instruction never reaches decode.
